// File: rtl/mul_issue_ctrl.sv
// Issue arbiter, destination hazard tracking and writeback stall control
// for the shared 2-stage multiplier in the execute stage.
module mul_issue_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       async_rst,
  input  logic                       clk_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [ADDR_W*NUM_REQ-1:0]  req_dest,
  input  logic [DATA_W*NUM_REQ-1:0]  req_a,
  input  logic [DATA_W*NUM_REQ-1:0]  req_b,
  output logic                       mul_sync_rst,
  output logic                       mul_clk_en,
  output logic                       mul_call,
  output logic [1:0]                 mul_operation,
  output logic [ADDR_W-1:0]          mul_dest_addr,
  output logic [DATA_W-1:0]          mul_data1,
  output logic [DATA_W-1:0]          mul_data2,
  input  logic [DATA_W-1:0]          mul_data_out,
  input  logic [ADDR_W-1:0]          mul_dest_addr_out,
  input  logic                       mul_valid,
  input  logic                       mul_empty,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [DATA_W-1:0]          wb_data,
  output logic [ADDR_W-1:0]          wb_dest,
  output logic [TAG_W-1:0]           wb_tag,
  output logic [(1<<ADDR_W)-1:0]     busy_regs,
  input  logic                       drain,
  output logic                       idle
);
  localparam int NREG = 1 << ADDR_W;

  logic [1:0]         rst_sync_q;
  logic [TAG_W-1:0]   prio_q, prio_d;
  logic [NREG-1:0]    busy_q, busy_d;
  logic               t1_v_q, t2_v_q;
  logic [TAG_W-1:0]   t1_tag_q, t2_tag_q;
  logic               stall, can_issue;
  logic               any_gnt, wb_fire;
  logic [NUM_REQ-1:0] elig;
  logic [TAG_W-1:0]   gnt_idx;

  // Reset asserts immediately, releases after two clean edges.
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};

  assign mul_sync_rst = rst_sync_q[1];
  assign stall        = mul_valid && !wb_ready;
  assign mul_clk_en   = clk_en && !stall;
  assign can_issue    = mul_clk_en && !drain && !mul_sync_rst;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] &&
                !busy_q[req_dest[i*ADDR_W +: ADDR_W]];
  end

  // prio_q is the first index scanned: one past the last grant.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    any_gnt   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(prio_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_gnt && can_issue && elig[j]) begin
        any_gnt      = 1'b1;
        req_ready[j] = 1'b1;
        gnt_idx      = TAG_W'(j);
      end
    end
  end

  assign mul_call      = any_gnt;
  assign mul_operation = req_op[int'(gnt_idx)*2 +: 2];
  assign mul_dest_addr = req_dest[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign mul_data1     = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign mul_data2     = req_b[int'(gnt_idx)*DATA_W +: DATA_W];

  assign wb_valid = mul_valid && !mul_sync_rst;
  assign wb_data  = mul_data_out;
  assign wb_dest  = mul_dest_addr_out;
  assign wb_tag   = t2_tag_q;
  assign wb_fire  = wb_valid && wb_ready && clk_en;

  always_comb begin
    busy_d = busy_q;
    prio_d = prio_q;
    if (wb_fire) busy_d[wb_dest] = 1'b0;
    if (any_gnt) begin
      busy_d[mul_dest_addr] = 1'b1;
      prio_d = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      busy_q   <= '0;
      prio_q   <= '0;
      t1_v_q   <= 1'b0;
      t2_v_q   <= 1'b0;
      t1_tag_q <= '0;
      t2_tag_q <= '0;
    end else begin
      busy_q <= busy_d;
      prio_q <= prio_d;
      if (mul_sync_rst) begin
        t1_v_q <= 1'b0;
        t2_v_q <= 1'b0;
      end else if (mul_clk_en) begin
        t1_v_q   <= mul_call;
        t1_tag_q <= gnt_idx;
        t2_v_q   <= t1_v_q;
        t2_tag_q <= t1_tag_q;
      end
    end
  end

  assign busy_regs = busy_q;
  assign idle      = mul_empty && (busy_q == '0);

  always_ff @(posedge clk) begin
    if (!async_rst && !mul_sync_rst) begin
      assert (t2_v_q == mul_valid)
        else $error("tag pipe out of step with multiplier");
      if (wb_fire)
        assert (busy_q[wb_dest])
          else $error("writeback clears an idle busy bit");
    end
    assert ($onehot0(req_ready))
      else $error("more than one grant");
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed steps then random traffic,
// checked against a queue-based model of the issue/writeback rules.
module tb_mul_issue_ctrl;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          async_rst, clk_en, drain, wb_ready;
  logic [N-1:0]  req_valid, req_ready;
  logic [2*N-1:0]  req_op;
  logic [AW*N-1:0] req_dest;
  logic [DW*N-1:0] req_a, req_b;
  logic          mul_sync_rst, mul_clk_en, mul_call;
  logic [1:0]    mul_operation;
  logic [AW-1:0] mul_dest_addr, mul_dest_addr_out, wb_dest;
  logic [DW-1:0] mul_data1, mul_data2, mul_data_out, wb_data;
  logic          mul_valid, mul_empty, wb_valid, idle;
  logic [0:0]    wb_tag;
  logic [NR-1:0] busy_regs;

  mul_issue_ctrl dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dest(req_dest),
    .req_a(req_a), .req_b(req_b),
    .mul_sync_rst(mul_sync_rst), .mul_clk_en(mul_clk_en),
    .mul_call(mul_call), .mul_operation(mul_operation),
    .mul_dest_addr(mul_dest_addr),
    .mul_data1(mul_data1), .mul_data2(mul_data2),
    .mul_data_out(mul_data_out),
    .mul_dest_addr_out(mul_dest_addr_out),
    .mul_valid(mul_valid), .mul_empty(mul_empty),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_dest(wb_dest), .wb_tag(wb_tag),
    .busy_regs(busy_regs), .drain(drain), .idle(idle)
  );

  function automatic logic [DW-1:0] mulres(logic [1:0] op,
                                           logic [DW-1:0] a,
                                           logic [DW-1:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[15:0] : p[31:16];
  endfunction

  // Two-stage multiplier standing in for the real unit.
  logic          s1v = 1'b0, s2v = 1'b0;
  logic [1:0]    s1op = '0;
  logic [AW-1:0] s1d = '0, s2d = '0;
  logic [DW-1:0] s1a = '0, s1b = '0, s2r = '0;

  always_ff @(posedge clk) begin
    if (mul_sync_rst) begin
      s1v <= 1'b0;
      s2v <= 1'b0;
    end else if (mul_clk_en) begin
      s1v  <= mul_call;
      s1op <= mul_operation;
      s1d  <= mul_dest_addr;
      s1a  <= mul_data1;
      s1b  <= mul_data2;
      s2v  <= s1v;
      s2d  <= s1d;
      s2r  <= mulres(s1op, s1a, s1b);
    end
  end

  assign mul_valid         = s2v;
  assign mul_data_out      = s2r;
  assign mul_dest_addr_out = s2d;
  assign mul_empty         = !s1v && !s2v;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
    int            tag;
    int            age;
  } ent_t;

  ent_t q[$];
  bit   busy_m[NR];
  int   last, srst_cnt;
  int   vectors, miscompares;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    last     = N - 1;
    srst_cnt = 2;
  endtask

  function automatic logic [AW-1:0] dst(int j);
    return req_dest[j*AW +: AW];
  endfunction

  task automatic setreq(int i, bit v, logic [1:0] op,
                        logic [AW-1:0] d, logic [DW-1:0] a,
                        logic [DW-1:0] b);
    req_valid[i]         = v;
    req_op[i*2 +: 2]     = op;
    req_dest[i*AW +: AW] = d;
    req_a[i*DW +: DW]    = a;
    req_b[i*DW +: DW]    = b;
  endtask

  // Inputs are set at posedge+1; checks at +3; model moves at the edge.
  task automatic step();
    int g;
    bit ewb, estall, adv;
    logic [NR-1:0] eb;
    logic [63:0] er;
    ent_t e;
    if (async_rst) mreset();
    #2;
    ewb    = q.size() > 0 && q[0].age == 2 && srst_cnt == 0;
    estall = ewb && !wb_ready;
    g = -1;
    if (srst_cnt == 0 && clk_en && !estall && !drain)
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (g < 0 && req_valid[j] && !busy_m[dst(j)]) g = j;
      end
    er = (g < 0) ? 64'd0 : (64'd1 << g);
    foreach (busy_m[i]) eb[i] = busy_m[i];
    chk("srst", mul_sync_rst, srst_cnt > 0);
    chk("ready", req_ready, er);
    chk("call", mul_call, g >= 0);
    chk("wbv", wb_valid, ewb);
    chk("busy", busy_regs, eb);
    if (ewb) begin
      chk("wbdata", wb_data, q[0].data);
      chk("wbdest", wb_dest, q[0].dest);
      chk("wbtag", wb_tag, q[0].tag);
    end
    if (!async_rst) begin
      chk("clken", mul_clk_en, clk_en && !estall);
      chk("idle", idle, q.size() == 0);
    end
    if (g >= 0) begin
      chk("op", mul_operation, req_op[g*2 +: 2]);
      chk("mdest", mul_dest_addr, dst(g));
      chk("d1", mul_data1, req_a[g*DW +: DW]);
      chk("d2", mul_data2, req_b[g*DW +: DW]);
    end
    @(posedge clk);
    if (async_rst) begin
      srst_cnt = 2;
    end else begin
      if (srst_cnt > 0) srst_cnt--;
      adv = clk_en && !estall;
      if (ewb && wb_ready && clk_en) begin
        busy_m[q[0].dest] = 1'b0;
        void'(q.pop_front());
      end
      if (adv) foreach (q[i]) q[i].age++;
      if (g >= 0) begin
        e.data = mulres(req_op[g*2 +: 2], req_a[g*DW +: DW],
                        req_b[g*DW +: DW]);
        e.dest = dst(g);
        e.tag  = g;
        e.age  = 1;
        q.push_back(e);
        busy_m[e.dest] = 1'b1;
        last = g;
      end
    end
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    async_rst = 1'b1;
    clk_en = 1'b1;
    drain = 1'b0;
    wb_ready = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_dest = '0;
    req_a = '0;
    req_b = '0;
    mreset();
    #3;
    chk("rst_ready", req_ready, 0);
    chk("rst_call", mul_call, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_busy", busy_regs, 0);
    chk("rst_idle", idle, 1);
    chk("rst_srst", mul_sync_rst, 1);
    @(posedge clk); #1;
    step();
    async_rst = 1'b0;
    step();
    step();
    chk("srst_rel", mul_sync_rst, 0);

    setreq(0, 1, 2'b00, 4'd2, 16'h0003, 16'h0005);
    step();
    setreq(0, 0, 2'b00, 4'd2, 16'h0003, 16'h0005);
    chk("single_busy", busy_regs[2], 1);
    step();
    chk("single_wbv", wb_valid, 1);
    chk("single_data", wb_data, 16'h000F);
    chk("single_dest", wb_dest, 2);
    chk("single_tag", wb_tag, 0);
    step();
    chk("single_clr", busy_regs[2], 0);

    for (int c = 0; c < 6; c++) begin
      setreq(0, 1, 2'(c), 4'(c), 16'(c + 1), 16'h0101);
      setreq(1, 1, 2'(c + 1), 4'(c + 8), 16'h8000, 16'(c + 7));
      step();
    end
    req_valid = '0;
    repeat (3) step();

    setreq(0, 1, 2'b00, 4'd5, 16'h0007, 16'h0009);
    step();
    setreq(0, 1, 2'b00, 4'd6, 16'h0011, 16'h0002);
    setreq(1, 1, 2'b11, 4'd5, 16'hFFFF, 16'hFFFF);
    repeat (4) step();
    req_valid = '0;
    repeat (3) step();

    setreq(0, 1, 2'b00, 4'd7, 16'h0012, 16'h0003);
    step();
    setreq(0, 1, 2'b10, 4'd8, 16'hFFFE, 16'h8000);
    step();
    wb_ready = 1'b0;
    setreq(0, 1, 2'b00, 4'd9, 16'h0001, 16'h0001);
    setreq(1, 1, 2'b00, 4'd10, 16'h0002, 16'h0002);
    repeat (3) step();
    wb_ready = 1'b1;
    req_valid = '0;
    repeat (4) step();

    setreq(0, 1, 2'b01, 4'd3, 16'hFFFF, 16'h0002);
    step();
    req_valid = '0;
    step();
    chk("signed_hi", wb_data, 16'hFFFF);
    step();

    setreq(0, 1, 2'b00, 4'd4, 16'h0005, 16'h0005);
    step();
    req_valid = '0;
    async_rst = 1'b1;
    #1;
    chk("arst_busy", busy_regs, 0);
    chk("arst_wbv", wb_valid, 0);
    step();
    async_rst = 1'b0;
    repeat (4) step();

    setreq(0, 1, 2'b00, 4'd11, 16'h0004, 16'h0004);
    step();
    drain = 1'b1;
    setreq(0, 1, 2'b00, 4'd12, 16'h0001, 16'h0002);
    setreq(1, 1, 2'b00, 4'd13, 16'h0003, 16'h0004);
    repeat (4) step();
    chk("drain_idle", idle, 1);
    drain = 1'b0;
    req_valid = '0;
    step();

    for (int c = 0; c < 3000; c++) begin
      async_rst = ($urandom_range(0, 199) == 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      wb_ready  = ($urandom_range(0, 9) < 7);
      drain     = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++)
        setreq(i, 1'($urandom), 2'($urandom), 4'($urandom),
               16'($urandom), 16'($urandom));
      step();
    end
    async_rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
